// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared definitions for the register file writeback path.
package regfile_writeback_arbiter_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int DEFAULT_XLEN = 32;

  // One writeback request. The pipeline stage that drives pipe_* uses it as well.
  typedef struct packed {
    logic                    en;
    logic [REG_ADDR_W-1:0]   addr;
    logic [DEFAULT_XLEN-1:0] data;
  } wb_req_t;

  // Register number to a one-hot bit in a NUM_REGS-wide mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] m;
    m       = '0;
    m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Bundle of the pipeline, late-result and register-file write signals.
// master drives the writeback sources. slave is the arbiter.
interface regfile_writeback_arbiter_if
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
);
  logic                  pipe_wr_en;
  logic [REG_ADDR_W-1:0] pipe_addr;
  logic [XLEN-1:0]       pipe_data;
  logic                  late_valid;
  logic                  late_ready;
  logic [REG_ADDR_W-1:0] late_addr;
  logic [XLEN-1:0]       late_data;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] addrD;
  logic [XLEN-1:0]       dataD;
  logic [NUM_REGS-1:0]   pending_mask;
  logic                  drain_req;

  modport master (
    output pipe_wr_en, pipe_addr, pipe_data,
    output late_valid, late_addr, late_data,
    input  late_ready,
    input  reg_write, addrD, dataD, pending_mask, drain_req
  );

  modport slave (
    input  pipe_wr_en, pipe_addr, pipe_data,
    input  late_valid, late_addr, late_data,
    output late_ready,
    output reg_write, addrD, dataD, pending_mask, drain_req
  );
endinterface

// File: rtl/regfile_writeback_arbiter_sync_fifo.sv
// In-order synchronous FIFO. The entry array and the per-entry valid bits are
// exported so the owner can build masks over everything that is buffered.
module sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [WIDTH-1:0]       entries [DEPTH],
  output logic [DEPTH-1:0]       valid
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic             do_push;
  logic             do_pop;

  // Pushes into a full FIFO are dropped even when a pop happens that cycle.
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_reg;
  assign rd_data = mem_reg[rd_ptr_reg];
  assign valid   = valid_reg;

  // Per-entry valid: set by the write pointer, cleared by the read pointer.
  // Both can only hit the same slot when empty or full, where one is blocked.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_comb begin
      valid_next[gi] = valid_reg[gi];
      if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
        valid_next[gi] = 1'b1;
      end else if (do_pop && (rd_ptr_reg == PTR_W'(gi))) begin
        valid_next[gi] = 1'b0;
      end
    end
    assign entries[gi] = mem_reg[gi];
  end

  // Storage array; no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers, occupancy and valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges the in-order pipeline writeback and buffered late results onto the
// single register file write port. The pipeline always wins. Late results
// drain on idle writeback cycles and are tracked in pending_mask.
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  regfile_writeback_arbiter_if.slave  bus
);
  localparam int ENTRY_W = REG_ADDR_W + XLEN;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic                  pipe_req;
  logic                  late_push;
  logic                  fifo_pop;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [ENTRY_W-1:0]    fifo_entries [DEPTH];
  logic [DEPTH-1:0]      fifo_valid;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  reg_write_reg;
  logic [REG_ADDR_W-1:0] addr_reg;
  logic [XLEN-1:0]       data_reg;
  logic [NUM_REGS-1:0]   entry_mask [DEPTH];
  logic [NUM_REGS-1:0]   pending_bits;

  // A write to x0 is an idle writeback cycle and frees the port for the FIFO.
  assign pipe_req  = bus.pipe_wr_en & (bus.pipe_addr != '0);
  // Late results for x0 complete the handshake but are never buffered.
  assign late_push = bus.late_valid & bus.late_ready & (bus.late_addr != '0);
  assign fifo_pop  = ~pipe_req & ~fifo_empty;

  // Ready depends only on the registered count, never on this cycle's pop.
  assign bus.late_ready = ~reset & ~fifo_full;
  assign bus.drain_req  = fifo_full;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_late_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (late_push),
    .wr_data ({bus.late_addr, bus.late_data}),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .entries (fifo_entries),
    .valid   (fifo_valid)
  );

  // Output stage: pipeline write, else FIFO head, else idle with address/data held.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_reg <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
    end else if (pipe_req) begin
      reg_write_reg <= 1'b1;
      addr_reg      <= bus.pipe_addr;
      data_reg      <= bus.pipe_data;
    end else if (fifo_pop) begin
      reg_write_reg <= 1'b1;
      addr_reg      <= fifo_head[ENTRY_W-1 -: REG_ADDR_W];
      data_reg      <= fifo_head[XLEN-1:0];
    end else begin
      reg_write_reg <= 1'b0;
    end
  end

  assign bus.reg_write = reg_write_reg;
  assign bus.addrD     = addr_reg;
  assign bus.dataD     = data_reg;

  // One-hot destination of every buffered entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pending
    assign entry_mask[gi] = fifo_valid[gi]
                          ? reg_onehot(fifo_entries[gi][ENTRY_W-1 -: REG_ADDR_W])
                          : '0;
  end

  // Pending writes: everything in the FIFO plus the write in the output stage.
  always_comb begin
    pending_bits = reg_write_reg ? reg_onehot(addr_reg) : '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_bits = pending_bits | entry_mask[i];
    end
    pending_bits[0] = 1'b0;
  end

  assign bus.pending_mask = pending_bits;

  // The count itself is only used through full/empty here.
  logic unused_count;
  assign unused_count = ^fifo_count;
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench for regfile_writeback_arbiter: every driven cycle pushes
// the expected output-stage contents, which are popped after the next edge.
module tb_regfile_writeback_arbiter;
  import regfile_writeback_arbiter_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_writeback_arbiter_if #(.XLEN(XLEN)) bus ();

  regfile_writeback_arbiter #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wb_req_t     model_fifo [$];
  wb_req_t     sb_q [$];
  logic        model_wr;
  logic [4:0]  model_addr;
  logic [31:0] model_data;
  bit          late_taken;
  int          checks = 0;
  int          passes = 0;

  task automatic drive(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.pipe_wr_en = pe;
    bus.pipe_addr  = pa;
    bus.pipe_data  = pd;
    bus.late_valid = lv;
    bus.late_addr  = la;
    bus.late_data  = ld;
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = 32'h0;
    foreach (model_fifo[i]) m = m | (32'h1 << model_fifo[i].addr);
    if (model_wr) m = m | (32'h1 << model_addr);
    m[0] = 1'b0;
    return m;
  endfunction

  // One clock of traffic: check state-derived outputs, predict, clock, compare.
  task automatic step();
    wb_req_t     exp;
    wb_req_t     got;
    logic        ready_exp;
    logic [31:0] mask_exp;
    ready_exp = (model_fifo.size() != DEPTH);
    mask_exp  = model_mask();
    checks++;
    if (bus.late_ready !== ready_exp) $display("FAIL late_ready: got %b need %b", bus.late_ready, ready_exp);
    else passes++;
    checks++;
    if (bus.drain_req !== !ready_exp) $display("FAIL drain_req: got %b need %b", bus.drain_req, !ready_exp);
    else passes++;
    checks++;
    if (bus.pending_mask !== mask_exp) $display("FAIL pending_mask: got %08h need %08h", bus.pending_mask, mask_exp);
    else passes++;
    if (bus.pipe_wr_en && bus.pipe_addr != 5'd0) exp = '{en: 1'b1, addr: bus.pipe_addr, data: bus.pipe_data};
    else if (model_fifo.size() > 0) exp = model_fifo.pop_front();
    else exp = '{en: 1'b0, addr: model_addr, data: model_data};
    sb_q.push_back(exp);
    late_taken = bus.late_valid && ready_exp;
    if (late_taken && bus.late_addr != 5'd0)
      model_fifo.push_back('{en: 1'b1, addr: bus.late_addr, data: bus.late_data});
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    if (bus.reg_write === 1'b1) $display("t=%0t write x%0d <= %08h", $time, bus.addrD, bus.dataD);
    checks++;
    if (bus.reg_write !== got.en) $display("FAIL reg_write: got %b need %b", bus.reg_write, got.en);
    else passes++;
    checks++;
    if (bus.addrD !== got.addr) $display("FAIL addrD: got %0d need %0d", bus.addrD, got.addr);
    else passes++;
    checks++;
    if (bus.dataD !== got.data) $display("FAIL dataD: got %08h need %08h", bus.dataD, got.data);
    else passes++;
    model_wr   = got.en;
    model_addr = got.addr;
    model_data = got.data;
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus.reg_write, bus.addrD, bus.dataD} !== 38'h0)
        $display("FAIL reset_outputs: got we=%b a=%0d d=%08h need all 0", bus.reg_write, bus.addrD, bus.dataD);
      else passes++;
      checks++;
      if ({bus.pending_mask, bus.drain_req, bus.late_ready} !== 34'h0)
        $display("FAIL reset_status: got mask=%08h drain=%b ready=%b need 0", bus.pending_mask, bus.drain_req, bus.late_ready);
      else passes++;
    end
    reset = 1'b0;
    model_fifo.delete();
    sb_q.delete();
    model_wr   = 1'b0;
    model_addr = 5'd0;
    model_data = 32'h0;
    #1;
    checks++;
    if (bus.late_ready !== 1'b1) $display("FAIL ready_after_reset: got %b need 1", bus.late_ready);
    else passes++;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2 * DEPTH + 2 && model_fifo.size() > 0; i++) step();
    step();
  endtask

  task automatic test_reset();
    apply_reset(2);
  endtask

  task automatic test_pipe_write();
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    step();
    checks++;
    if (bus.pending_mask !== 32'h0000_0020) $display("FAIL pipe_mask_set: got %08h need 00000020", bus.pending_mask);
    else passes++;
    drive(0, 0, 0, 0, 0, 0);
    step();
    checks++;
    if (bus.pending_mask !== 32'h0) $display("FAIL pipe_mask_clear: got %08h need 00000000", bus.pending_mask);
    else passes++;
  endtask

  task automatic test_late_held();
    drive(1, 1, 32'h11, 1, 7, 32'h1234);
    step();
    for (int i = 2; i <= 3; i++) begin
      checks++;
      if (bus.pending_mask[7] !== 1'b1) $display("FAIL late_held_mask: got %b need 1", bus.pending_mask[7]);
      else passes++;
      drive(1, 5'(i), 32'(i * 16 + i), 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    checks++;
    if ({bus.reg_write, bus.addrD, bus.dataD} !== {1'b1, 5'd7, 32'h1234})
      $display("FAIL late_emit: got we=%b a=%0d d=%08h need we=1 a=7 d=00001234", bus.reg_write, bus.addrD, bus.dataD);
    else passes++;
    step();
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 5'(10 + i), 32'hA00 + 32'(i), 1, 5'(16 + i), 32'h200 + 32'(i));
      step();
    end
    checks++;
    if ({bus.late_ready, bus.drain_req} !== 2'b01)
      $display("FAIL full_flags: got ready=%b drain=%b need ready=0 drain=1", bus.late_ready, bus.drain_req);
    else passes++;
    drive(1, 14, 32'hA04, 1, 20, 32'h204);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    checks++;
    if ({bus.late_ready, bus.drain_req, bus.addrD} !== {2'b10, 5'd16})
      $display("FAIL after_pop: got ready=%b drain=%b a=%0d need ready=1 drain=0 a=16", bus.late_ready, bus.drain_req, bus.addrD);
    else passes++;
    drain();
  endtask

  task automatic test_order_wrap();
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    while (sent < 10 && guard < 200) begin
      drive(logic'(guard % 2 == 0), 5'(24 + guard % 4), 32'hB00 + 32'(guard),
            1, 5'(sent + 1), 32'h100 + 32'(sent + 1));
      step();
      if (late_taken) sent++;
      guard++;
    end
    checks++;
    if (sent != 10) $display("FAIL order_sent: got %0d need 10", sent);
    else passes++;
    drain();
  endtask

  task automatic test_x0();
    drive(1, 1, 32'h1, 1, 9, 32'h99);
    step();
    drive(1, 0, 32'hBAD, 0, 0, 0);
    step();
    checks++;
    if ({bus.reg_write, bus.addrD, bus.dataD} !== {1'b1, 5'd9, 32'h99})
      $display("FAIL x0_pipe_drain: got we=%b a=%0d d=%08h need we=1 a=9 d=00000099", bus.reg_write, bus.addrD, bus.dataD);
    else passes++;
    drive(0, 0, 0, 1, 0, 32'hBAD);
    checks++;
    if (bus.late_ready !== 1'b1) $display("FAIL x0_late_ready: got %b need 1", bus.late_ready);
    else passes++;
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    checks++;
    if ({bus.reg_write, bus.pending_mask} !== 33'h0)
      $display("FAIL x0_late_dropped: got we=%b mask=%08h need 0", bus.reg_write, bus.pending_mask);
    else passes++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(1 + i), 32'h300 + 32'(i), 1, 5'(11 + i), 32'h400 + 32'(i));
      step();
    end
    checks++;
    if (bus.reg_write !== 1'b1 || bus.pending_mask[13:11] !== 3'b111)
      $display("FAIL pre_reset_state: got we=%b mask=%08h need we=1 bits 13:11 set", bus.reg_write, bus.pending_mask);
    else passes++;
    apply_reset(2);
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive(logic'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            logic'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      step();
    end
    drain();
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_wr   = 1'b0;
    model_addr = 5'd0;
    model_data = 32'h0;
    test_reset();
    test_pipe_write();
    test_late_held();
    test_fifo_full();
    test_order_wrap();
    test_x0();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout need completion");
    $fatal(1, "timeout");
  end
endmodule
